// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, owner
// encoding and the starvation-counter width.
package dmem_arbiter_pkg;

    localparam int MEM_RDATA_W = 80;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_ACK    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_L = 1'b1
    } owner_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles of the data-memory arbiter.
interface dmem_port_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MEM_RDATA_W = 80
);
    logic                   read;
    logic                   write;
    logic [ADDR_W-1:0]      read_addr;
    logic [ADDR_W-1:0]      write_addr;
    logic [DATA_W-1:0]      wdata;
    logic [MEM_RDATA_W-1:0] rdata;
    logic                   invalid;

    modport master (output read, write, read_addr, write_addr, wdata, input rdata, invalid);
    modport slave  (input read, write, read_addr, write_addr, wdata, output rdata, invalid);
endinterface

// File: rtl/dmem_arbiter_priority_pick.sv
// Fixed-priority pick with starvation override: C wins ties unless L has
// already been passed over STARVE_LIMIT times in a row.
module arb_priority_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             c_req,
    input  logic             l_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_c,
    output logic             grant_l
);

    logic l_forced;

    always_comb begin
        l_forced = l_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_c  = c_req && !l_forced;
        grant_l  = l_req && !grant_c;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU memory stage (C) and
// the loader/debug port (L) with fixed IDLE -> ACCESS -> ACK transactions.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    dmem_port_if.slave c_port,
    dmem_port_if.slave l_port,
    dmem_mem_if.master mem
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t        state;
    arb_state_t        state_next;
    owner_t            owner;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_c;
    logic              grant_l;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^mem.rdata[MEM_RDATA_W-1:DATA_W];

    arb_priority_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .c_req      (c_port.req),
        .l_req      (l_port.req),
        .starve_cnt (starve_cnt),
        .grant_c    (grant_c),
        .grant_l    (grant_l)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE:   if (c_port.req || l_port.req) state_next = ARB_ACCESS;
            ARB_ACCESS: state_next = ARB_ACK;
            ARB_ACK:    state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    // Command is frozen in IDLE so requester changes mid-transaction are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_C;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == ARB_IDLE && grant_c) begin
                owner     <= OWN_C;
                cmd_we    <= c_port.we;
                cmd_addr  <= c_port.addr;
                cmd_wdata <= c_port.wdata;
            end else if (state == ARB_IDLE && grant_l) begin
                owner     <= OWN_L;
                cmd_we    <= l_port.we;
                cmd_addr  <= l_port.addr;
                cmd_wdata <= l_port.wdata;
            end
            if (state == ARB_ACCESS) begin
                resp_rdata <= cmd_we ? '0 : mem.rdata[DATA_W-1:0];
                resp_err   <= mem.invalid;
            end
        end
    end

    // Counts C wins while L waits; any IDLE cycle without an L request forgives the debt.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (!l_port.req || grant_l) starve_cnt <= '0;
            else if (grant_c)           starve_cnt <= sat_inc(starve_cnt, LIMIT);
        end
    end

    always_comb begin
        mem.read       = 1'b0;
        mem.write      = 1'b0;
        mem.read_addr  = '0;
        mem.write_addr = '0;
        mem.wdata      = '0;
        c_port.ack     = 1'b0;
        l_port.ack     = 1'b0;
        c_port.rdata   = resp_rdata;
        c_port.err     = resp_err;
        l_port.rdata   = resp_rdata;
        l_port.err     = resp_err;
        unique case (state)
            ARB_ACCESS: begin
                mem.read       = !cmd_we;
                mem.write      = cmd_we;
                mem.read_addr  = cmd_addr;
                mem.write_addr = cmd_addr;
                mem.wdata      = cmd_wdata;
            end
            ARB_ACK: begin
                c_port.ack = (owner == OWN_C);
                l_port.ack = (owner == OWN_L);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array data memory plus a transaction-level
// reference (shadow memory and grant-order model) checked per scenario.
module tb_dmem_arbiter;

    localparam int          LIMIT    = 4;
    localparam int          MEM_SIZE = 1024;
    localparam logic [63:0] LAST_OK  = 64'd1016;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_port_if #(.ADDR_W(64), .DATA_W(64)) c_bus ();
    dmem_port_if #(.ADDR_W(64), .DATA_W(64)) l_bus ();
    dmem_mem_if  #(.ADDR_W(64), .DATA_W(64), .MEM_RDATA_W(80)) mem_bus ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .c_port (c_bus),
        .l_port (l_bus),
        .mem    (mem_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [0:MEM_SIZE-1];
    logic [7:0] ref_mem [0:MEM_SIZE-1];
    int         errors = 0;
    int         checks = 0;
    int         c_ack_count = 0;
    txn_t       c_q[$];
    txn_t       l_q[$];
    string      ack_order;

    // Data memory: combinational read and error flag, write commits on negedge.
    always_comb begin
        logic [63:0] a;
        a               = mem_bus.read ? mem_bus.read_addr : mem_bus.write_addr;
        mem_bus.invalid = (mem_bus.read || mem_bus.write) && (a > LAST_OK);
        mem_bus.rdata   = {16'hFFFF, 64'h0};
        if (mem_bus.read && !mem_bus.invalid)
            for (int i = 0; i < 8; i++) mem_bus.rdata[8*i +: 8] = mem[int'(a[9:0]) + i];
    end

    always @(negedge clk) begin
        if (mem_bus.write && !mem_bus.invalid)
            for (int i = 0; i < 8; i++) mem[int'(mem_bus.write_addr[9:0]) + i] = mem_bus.wdata[8*i +: 8];
    end

    always @(posedge clk) begin
        #1;
        if (c_bus.ack) c_ack_count++;
        if (c_bus.ack || l_bus.ack) begin
            checks++;
            if (c_bus.ack && l_bus.ack) begin
                errors++;
                $display("FAIL dual_ack: c_ack=%b l_ack=%b, expected at most one", c_bus.ack, l_bus.ack);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] addr);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(addr[9:0]) + i];
        return v;
    endfunction

    function automatic void ref_write(input logic [63:0] addr, input logic [63:0] data);
        for (int i = 0; i < 8; i++) ref_mem[int'(addr[9:0]) + i] = data[8*i +: 8];
    endfunction

    function automatic logic [325:0] outs();
        return {c_bus.ack, c_bus.rdata, c_bus.err, l_bus.ack, l_bus.rdata, l_bus.err,
                mem_bus.read, mem_bus.write, mem_bus.read_addr, mem_bus.write_addr, mem_bus.wdata};
    endfunction

    function automatic logic port_ack(input bit is_l);
        return is_l ? l_bus.ack : c_bus.ack;
    endfunction

    task automatic set_port(input bit is_l, input logic req, input txn_t t);
        if (is_l) begin
            l_bus.req = req; l_bus.we = t.we; l_bus.addr = t.addr; l_bus.wdata = t.wdata;
        end else begin
            c_bus.req = req; c_bus.we = t.we; c_bus.addr = t.addr; c_bus.wdata = t.wdata;
        end
    endtask

    // Grant order for two requesters holding req until their queues drain.
    function automatic string predict_order(input int nc, input int nl);
        string s = "";
        int    cnt = 0;
        while (nc > 0 || nl > 0) begin
            if (nc > 0 && (nl == 0 || cnt != LIMIT)) begin
                s = {s, "C"};
                nc--;
                cnt = (nl > 0) ? ((cnt < LIMIT) ? cnt + 1 : LIMIT) : 0;
            end else begin
                s = {s, "L"};
                nl--;
                cnt = 0;
            end
        end
        return s;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = $urandom_range(0, 1) == 1;
        t.wdata = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       t.addr = 64'($urandom_range(1017, 1200));
            1, 2:    t.addr = 64'($urandom_range(0, 1016));
            default: t.addr = 64'($urandom_range(0, 15)) * 8;
        endcase
        return t;
    endfunction

    task automatic run_txn(input bit is_l, input txn_t t, output logic [63:0] rdata,
                           output logic err, output int lat);
        set_port(is_l, 1'b1, t);
        lat = 0;
        do begin step(); lat++; end while (!port_ack(is_l) && lat < 50);
        rdata = is_l ? l_bus.rdata : c_bus.rdata;
        err   = is_l ? l_bus.err : c_bus.err;
        if (!port_ack(is_l)) begin
            checks++; errors++;
            $display("FAIL txn_timeout: port %s no ack within 50 cycles", is_l ? "L" : "C");
            lat = -1;
        end else if (t.we && t.addr <= LAST_OK) begin
            ref_write(t.addr, t.wdata);
        end
        set_port(is_l, 1'b0, t);
        step();
    endtask

    task automatic drive_port(input bit is_l);
        txn_t        t;
        int          waited;
        logic [63:0] exp;
        logic        exp_err;
        logic [63:0] got;
        logic        got_err;
        while ((is_l ? l_q.size() : c_q.size()) > 0) begin
            if (is_l) t = l_q.pop_front();
            else      t = c_q.pop_front();
            set_port(is_l, 1'b1, t);
            waited = 0;
            do begin step(); waited++; end while (!port_ack(is_l) && waited < 100);
            if (!port_ack(is_l)) begin
                checks++; errors++;
                $display("FAIL stream_timeout: port %s no ack within 100 cycles", is_l ? "L" : "C");
                set_port(is_l, 1'b0, t);
                return;
            end
            ack_order = {ack_order, is_l ? "L" : "C"};
            got     = is_l ? l_bus.rdata : c_bus.rdata;
            got_err = is_l ? l_bus.err : c_bus.err;
            exp_err = t.addr > LAST_OK;
            checks++;
            if (got_err !== exp_err) begin
                errors++;
                $display("FAIL stream_err: port %s addr=%h got %b expected %b", is_l ? "L" : "C", t.addr, got_err, exp_err);
            end
            if (t.we) begin
                exp = '0;
                if (!exp_err) ref_write(t.addr, t.wdata);
            end else begin
                exp = exp_err ? got : ref_read(t.addr);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stream_rdata: port %s addr=%h we=%b got %h expected %h", is_l ? "L" : "C", t.addr, t.we, got, exp);
            end
        end
        set_port(is_l, 1'b0, t);
    endtask

    task automatic test_reset();
        txn_t idle_t;
        idle_t = '{we: 1'b0, addr: 64'h0, wdata: 64'h0};
        set_port(1'b0, 1'b0, idle_t);
        set_port(1'b1, 1'b0, idle_t);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        step();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0", outs());
        end
    endtask

    task automatic test_c_read();
        c_bus.req = 1'b1; c_bus.we = 1'b0; c_bus.addr = 64'h10; c_bus.wdata = {$urandom(), $urandom()};
        step();
        checks++;
        if (c_bus.ack !== 1'b0 || mem_bus.read !== 1'b1 || mem_bus.write !== 1'b0 || mem_bus.read_addr !== 64'h10) begin
            errors++;
            $display("FAIL c_read_access: ack=%b read=%b write=%b raddr=%h expected 0 1 0 10",
                     c_bus.ack, mem_bus.read, mem_bus.write, mem_bus.read_addr);
        end
        step();
        checks++;
        if (c_bus.ack !== 1'b1 || l_bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL c_read_ack: c_ack=%b l_ack=%b expected 1 0", c_bus.ack, l_bus.ack);
        end
        checks++;
        if (c_bus.rdata !== 64'h0807060504030201 || c_bus.err !== 1'b0) begin
            errors++;
            $display("FAIL c_read_data: rdata=%h err=%b expected 0807060504030201 0", c_bus.rdata, c_bus.err);
        end
        c_bus.req = 1'b0;
        step();
        checks++;
        if (c_bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL c_read_pulse: c_ack=%b expected 0", c_bus.ack);
        end
    endtask

    task automatic test_l_write_read();
        int          c0 = c_ack_count;
        logic [63:0] rd;
        logic        er;
        int          lat;
        txn_t        t;
        t = '{we: 1'b1, addr: 64'h100, wdata: 64'hDEADBEEFCAFEF00D};
        run_txn(1'b1, t, rd, er, lat);
        checks++;
        if (lat != 2 || rd !== 64'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL l_write: lat=%0d rdata=%h err=%b expected 2 0 0", lat, rd, er);
        end
        t.we = 1'b0;
        run_txn(1'b1, t, rd, er, lat);
        checks++;
        if (lat != 2 || rd !== 64'hDEADBEEFCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL l_read: lat=%0d rdata=%h err=%b expected 2 deadbeefcafef00d 0", lat, rd, er);
        end
        checks++;
        if (c_ack_count != c0) begin
            errors++;
            $display("FAIL l_no_c_ack: c_ack pulses=%0d expected 0", c_ack_count - c0);
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 8; i++) begin txn_t t; t = rand_txn(); t.we = 1'b0; c_q.push_back(t); end
        for (int i = 0; i < 2; i++) begin txn_t t; t = rand_txn(); t.we = 1'b0; l_q.push_back(t); end
        ack_order = "";
        fork
            drive_port(1'b0);
            drive_port(1'b1);
        join
        checks++;
        if (ack_order != "CCCCLCCCCL") begin
            errors++;
            $display("FAIL starve_order: got %s expected CCCCLCCCCL", ack_order);
        end
        step();
    endtask

    task automatic test_error();
        logic [63:0] rd;
        logic        er;
        int          lat;
        txn_t        t;
        t = '{we: 1'b0, addr: 64'd1020, wdata: 64'h0};
        run_txn(1'b0, t, rd, er, lat);
        checks++;
        if (lat != 2 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_high: lat=%0d err=%b expected 2 1", lat, er);
        end
        t.addr = 64'd8;
        run_txn(1'b0, t, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== ref_read(64'd8)) begin
            errors++;
            $display("FAIL err_clear: rdata=%h err=%b expected %h 0", rd, er, ref_read(64'd8));
        end
    endtask

    task automatic test_mid_reset();
        int          c0;
        logic [63:0] rd;
        logic        er;
        int          lat;
        txn_t        t;
        // Rewrites the current contents so the abandoned write cannot disturb later reads.
        t = '{we: 1'b1, addr: 64'h3F0, wdata: ref_read(64'h3F0)};
        set_port(1'b0, 1'b1, t);
        step();
        checks++;
        if (mem_bus.write !== 1'b1) begin
            errors++;
            $display("FAIL midrst_access: m_write=%b expected 1", mem_bus.write);
        end
        c0  = c_ack_count;
        rst = 1'b1;
        set_port(1'b0, 1'b0, t);
        step();
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0", outs());
        end
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (c_ack_count != c0) begin
            errors++;
            $display("FAIL midrst_no_ack: c_ack pulses=%0d expected 0", c_ack_count - c0);
        end
        t.we = 1'b0;
        run_txn(1'b0, t, rd, er, lat);
        checks++;
        if (lat != 2 || rd !== ref_read(64'h3F0) || er !== 1'b0) begin
            errors++;
            $display("FAIL midrst_recover: lat=%0d rdata=%h err=%b expected 2 %h 0", lat, rd, er, ref_read(64'h3F0));
        end
    endtask

    task automatic test_addr_change();
        logic [63:0] exp = ref_read(64'h10);
        c_bus.req = 1'b1; c_bus.we = 1'b0; c_bus.addr = 64'h10; c_bus.wdata = 64'h0;
        step();
        c_bus.addr = 64'h200; c_bus.we = 1'b1; c_bus.wdata = {$urandom(), $urandom()};
        checks++;
        if (mem_bus.read_addr !== 64'h10 || mem_bus.read !== 1'b1 || mem_bus.write !== 1'b0) begin
            errors++;
            $display("FAIL latch_cmd: raddr=%h read=%b write=%b expected 10 1 0",
                     mem_bus.read_addr, mem_bus.read, mem_bus.write);
        end
        step();
        checks++;
        if (c_bus.ack !== 1'b1 || c_bus.rdata !== exp) begin
            errors++;
            $display("FAIL latch_data: ack=%b rdata=%h expected 1 %h", c_bus.ack, c_bus.rdata, exp);
        end
        c_bus.req = 1'b0;
        step();
    endtask

    task automatic test_random();
        int    nc;
        int    nl;
        string exp_order;
        for (int it = 0; it < 25; it++) begin
            nc = $urandom_range(0, 6);
            nl = $urandom_range(0, 3);
            for (int i = 0; i < nc; i++) c_q.push_back(rand_txn());
            for (int i = 0; i < nl; i++) l_q.push_back(rand_txn());
            exp_order = predict_order(nc, nl);
            ack_order = "";
            fork
                drive_port(1'b0);
                drive_port(1'b1);
            join
            checks++;
            if (ack_order != exp_order) begin
                errors++;
                $display("FAIL random_order: iter %0d got %s expected %s", it, ack_order, exp_order);
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 8'($urandom());
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) begin
            mem[16 + i]     = 8'(i + 1);
            ref_mem[16 + i] = 8'(i + 1);
        end
        test_reset();
        test_c_read();
        test_l_write_read();
        test_starvation();
        test_error();
        test_mid_reset();
        test_addr_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
